hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. It generates the per-stage `stall_*`/`flush_*` controls consumed by the F/D, D/E, E/M and M/W pipeline registers, and the E-stage operand forwarding selects. It also sequences data-memory wait states with a timeout watchdog and keeps stall/flush event counters. It sits beside the datapath and observes register addresses, write enables and memory handshake signals.

## Interface
Parameters:
- `MEM_TIMEOUT`, 256: maximum consecutive wait cycles on one memory access before the error state; legal range ≥ 2.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rs1_addr_D`, `rs2_addr_D` in 5 each: D-stage source registers.
- `rs1_addr_E`, `rs2_addr_E` in 5 each: E-stage source registers.
- `rd_E`, `rd_M`, `rd_W` in 5 each: destination registers per stage.
- `mem_rd_E` in 1: E-stage instruction is a load.
- `reg_wr_M`, `reg_wr_W` in 1 each: register write enables for M and W.
- `br_taken_E` in 1: branch or jump resolved taken in E (PC redirect).
- `mem_req_M` in 1: M-stage instruction accesses data memory.
- `mem_ready` in 1: data memory completes the access this cycle.
- `stall_F`, `stall_D`, `stall_E`, `stall_M` out 1 each: hold the PC / F-D / D-E / E-M register.
- `flush_D`, `flush_E`, `flush_W` out 1 each: load a bubble into the F-D / D-E / M-W register.
- `fwd_a_E`, `fwd_b_E` out 2 each: ALU operand source; 00 = register file, 01 = W result, 10 = M result.
- `mem_err` out 1: sticky memory-timeout flag.
- `stall_cycles` out 32: count of cycles with `stall_D`=1.
- `flush_events` out 32: count of cycles with `flush_E`=1.

## Operation
- Forwarding for `fwd_a_E`, combinational:
  - 10 if `reg_wr_M`, `rd_M`≠0 and `rd_M`==`rs1_addr_E`.
  - Otherwise 01 if `reg_wr_W`, `rd_W`≠0 and `rd_W`==`rs1_addr_E`.
  - Otherwise 00.
  - Same rule for `fwd_b_E` using `rs2_addr_E`. The M match wins over the W match.
- `freeze` = (state==RUN & `mem_req_M` & ~`mem_ready`) | (state==WAIT & ~`mem_ready`) | (state==ERR).
- `load_use` = `mem_rd_E` & `rd_E`≠0 & (`rd_E`==`rs1_addr_D` | `rd_E`==`rs2_addr_D`).
- Control priority, highest first:
  - **freeze:** all `stall_*`=1, `flush_W`=1, `flush_D`=`flush_E`=0. Flush must not be asserted during freeze, because pipeline-register flush overrides stall.
  - **`br_taken_E`:** `flush_D`=`flush_E`=1, no stalls. Any load-use condition is ignored because the D instruction is wrong-path.
  - **load_use:** `stall_F`=`stall_D`=1, `flush_E`=1.
  - **Otherwise:** all stall and flush outputs 0.
- FSM states and transitions:
  - RUN → WAIT on `mem_req_M` & ~`mem_ready`; `wait_cnt` is set to 1.
  - WAIT → RUN on `mem_ready`; `wait_cnt` is set to 0.
  - WAIT stays in WAIT while ~`mem_ready`; `wait_cnt` increments.
  - WAIT → ERR when ~`mem_ready` and `wait_cnt`==`MEM_TIMEOUT`-1.
  - ERR is left only by `reset`. `mem_err`=1 in ERR.
- Width of `wait_cnt` = $clog2(`MEM_TIMEOUT`+1).
- Counters increment by 1 per qualifying cycle and wrap modulo 2^32. Reset clears them.

## Timing
- Stall, flush and forwarding outputs are combinational from the inputs and current state. There are zero cycles of latency, so the controls take effect at the same clock edge.
- Cycle with `mem_ready`=1 while in WAIT: `freeze`=0 and the pipeline advances at that edge. A 1-cycle `mem_req_M` that is already ready causes no stall.
- `mem_err`, `stall_cycles` and `flush_events` are registered and update one cycle after the event.
- While `reset`=1, all `stall_*`, `flush_*`, `fwd_*` and `mem_err` outputs are 0 regardless of inputs. After the reset edge: state=RUN, `wait_cnt`=0, counters=0, `mem_err`=0.
- Reset asserted mid-WAIT or in ERR: state returns to RUN on that edge and the pending access is abandoned.
- `br_taken_E` during freeze is not lost: the E register is held, so the branch is presented again after release.

## Structure
- Shared package `hazard_pkg`:
  - `fwd_sel_t` enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - `hz_state_t` enum: RUN, WAIT, ERR.
- Sub-module `fwd_unit`, combinational. Inputs: source address, `rd_M`, `reg_wr_M`, `rd_W`, `reg_wr_W`. Output: `fwd_sel_t`. Instantiated twice, once per operand.
- FSM, watchdog counter and event counters are implemented in `hazard_ctrl`.

## Test plan
- Forwarding priority: `rs1_addr_E`=5, `rd_M`=5, `reg_wr_M`=1, `rd_W`=5, `reg_wr_W`=1 → `fwd_a_E`=10. Change `rd_M` to 0 → 01. Set `rd_W`=0 as well → 00.
- Load-use: `mem_rd_E`=1, `rd_E`=7, `rs2_addr_D`=7 → `stall_F`=`stall_D`=`flush_E`=1 for one cycle; `stall_cycles`=1 and `flush_events`=1 the next cycle. With `rd_E`=0 → no stall.
- Branch versus load-use in the same cycle: `br_taken_E`=1 with the load-use condition true → `flush_D`=`flush_E`=1 and `stall_D`=0.
- Memory wait: `mem_req_M`=1 with `mem_ready` low for 3 cycles, then high → all stalls and `flush_W` high for exactly 3 cycles, low on the ready cycle. `br_taken_E`=1 throughout never produces `flush_E` during the wait.
- Timeout with `MEM_TIMEOUT`=4: `mem_ready` held low → `mem_err`=1 after the fourth wait cycle, stalls stay high. Asserting `reset` clears `mem_err` and both counters and returns to RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// hazard_pkg: shared types for the pipeline hazard controller.
// Revision 1.0

package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } hz_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_ctrl_fwd_unit.sv
`default_nettype none
// fwd_unit: selects the E-stage operand source for one source register.
// Revision 1.0

module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] src_addr,
    input  logic [4:0] rd_M,
    input  logic       reg_wr_M,
    input  logic [4:0] rd_W,
    input  logic       reg_wr_W,
    output fwd_sel_t   sel
);

    // The M-stage result is younger than the W-stage result, so it wins.
    always_comb begin
        sel = FWD_RF;
        if (reg_wr_M && (rd_M != 5'd0) && (rd_M == src_addr)) begin
            sel = FWD_MEM;
        end else if (reg_wr_W && (rd_W != 5'd0) && (rd_W == src_addr)) begin
            sel = FWD_WB;
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// hazard_ctrl: stall/flush/forward control with memory wait sequencing and event counters.
// Revision 1.0

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr_D,
    input  logic [4:0]  rs2_addr_D,
    input  logic [4:0]  rs1_addr_E,
    input  logic [4:0]  rs2_addr_E,
    input  logic [4:0]  rd_E,
    input  logic [4:0]  rd_M,
    input  logic [4:0]  rd_W,
    input  logic        mem_rd_E,
    input  logic        reg_wr_M,
    input  logic        reg_wr_W,
    input  logic        br_taken_E,
    input  logic        mem_req_M,
    input  logic        mem_ready,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        flush_D,
    output logic        flush_E,
    output logic        flush_W,
    output logic [1:0]  fwd_a_E,
    output logic [1:0]  fwd_b_E,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_err_q;
    fwd_sel_t          fwd_a;
    fwd_sel_t          fwd_b;
    logic              freeze;
    logic              load_use;

    fwd_unit u_fwd_a (
        .src_addr (rs1_addr_E),
        .rd_M     (rd_M),
        .reg_wr_M (reg_wr_M),
        .rd_W     (rd_W),
        .reg_wr_W (reg_wr_W),
        .sel      (fwd_a)
    );

    fwd_unit u_fwd_b (
        .src_addr (rs2_addr_E),
        .rd_M     (rd_M),
        .reg_wr_M (reg_wr_M),
        .rd_W     (rd_W),
        .reg_wr_W (reg_wr_W),
        .sel      (fwd_b)
    );

    assign fwd_a_E = reset ? 2'b00 : fwd_a;
    assign fwd_b_E = reset ? 2'b00 : fwd_b;
    assign mem_err = mem_err_q & ~reset;

    assign freeze = ((state == RUN)  && mem_req_M && !mem_ready) ||
                    ((state == WAIT) && !mem_ready) ||
                    (state == ERR);

    assign load_use = mem_rd_E && (rd_E != 5'd0) &&
                      ((rd_E == rs1_addr_D) || (rd_E == rs2_addr_D));

    // Freeze never flushes D/E: a flush would override the hold and lose the instruction.
    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_W = 1'b0;
        if (!reset) begin
            if (freeze) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                flush_W = 1'b1;
            end else if (br_taken_E) begin
                flush_D = 1'b1;
                flush_E = 1'b1;
            end else if (load_use) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                flush_E = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            wait_cnt     <= '0;
            mem_err_q    <= 1'b0;
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req_M && !mem_ready) begin
                        state    <= WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state     <= ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase

            if (stall_D) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush_E) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// tb_hazard_ctrl: directed vectors with a queue-based scoreboard and decoupled monitor.
// Revision 1.0

module tb_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       mrdE, wrM, wrW, br, req, rdy;
    } vin_t;

    // st = {F,D,E,M}, fl = {D,E,W}
    typedef struct packed {
        logic [3:0]  st;
        logic [2:0]  fl;
        logic [1:0]  fa, fb;
        logic        err;
        logic [31:0] sc, fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_E, rd_M, rd_W;
    logic        mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E, mem_req_M, mem_ready;
    logic        stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W;
    logic [1:0]  fwd_a_E, fwd_b_E;
    logic        mem_err;
    logic [31:0] stall_cycles, flush_events;

    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .rs1_addr_D   (rs1_addr_D),
        .rs2_addr_D   (rs2_addr_D),
        .rs1_addr_E   (rs1_addr_E),
        .rs2_addr_E   (rs2_addr_E),
        .rd_E         (rd_E),
        .rd_M         (rd_M),
        .rd_W         (rd_W),
        .mem_rd_E     (mem_rd_E),
        .reg_wr_M     (reg_wr_M),
        .reg_wr_W     (reg_wr_W),
        .br_taken_E   (br_taken_E),
        .mem_req_M    (mem_req_M),
        .mem_ready    (mem_ready),
        .stall_F      (stall_F),
        .stall_D      (stall_D),
        .stall_E      (stall_E),
        .stall_M      (stall_M),
        .flush_D      (flush_D),
        .flush_E      (flush_E),
        .flush_W      (flush_W),
        .fwd_a_E      (fwd_a_E),
        .fwd_b_E      (fwd_b_E),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    function automatic vin_t vi(input logic rst, input logic [4:0] rs1D, rs2D, rs1E, rs2E,
                                rdE, rdM, rdW, input logic mrdE, wrM, wrW, br, req, rdy);
        vin_t v;
        v = '{rst, rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, mrdE, wrM, wrW, br, req, rdy};
        return v;
    endfunction

    function automatic exp_t ex(input logic [3:0] st, input logic [2:0] fl,
                                input logic [1:0] fa, fb, input logic err,
                                input logic [31:0] sc, fe);
        exp_t e;
        e = '{st, fl, fa, fb, err, sc, fe};
        return e;
    endfunction

    task automatic drive(input vin_t v);
        reset      = v.rst;
        rs1_addr_D = v.rs1D;
        rs2_addr_D = v.rs2D;
        rs1_addr_E = v.rs1E;
        rs2_addr_E = v.rs2E;
        rd_E       = v.rdE;
        rd_M       = v.rdM;
        rd_W       = v.rdW;
        mem_rd_E   = v.mrdE;
        reg_wr_M   = v.wrM;
        reg_wr_W   = v.wrW;
        br_taken_E = v.br;
        mem_req_M  = v.req;
        mem_ready  = v.rdy;
    endtask

    task automatic apply(input vin_t v, input exp_t e);
        @(posedge clk);
        #1;
        drive(v);
        sb_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL vec %0d %s: got %0h expected %0h", vec_no, name, got, want);
        end
    endtask

    // Monitor: one vector per cycle, sampled mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("stalls",       32'({stall_F, stall_D, stall_E, stall_M}), 32'(e.st));
                check("flushes",      32'({flush_D, flush_E, flush_W}),          32'(e.fl));
                check("fwd_a_E",      32'(fwd_a_E),                              32'(e.fa));
                check("fwd_b_E",      32'(fwd_b_E),                              32'(e.fb));
                check("mem_err",      32'(mem_err),                              32'(e.err));
                check("stall_cycles", stall_cycles,                              e.sc);
                check("flush_events", flush_events,                              e.fe);
                vec_no++;
            end
        end
    end

    initial begin
        drive(vi(1, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0));
        repeat (2) @(posedge clk);

        //          rst rs1D rs2D rs1E rs2E rdE rdM rdW mrd wrM wrW br req rdy
        // Reset with a branch and load-use present: everything held at zero.
        apply(vi(1, 7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 1, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
        // Forwarding priority.
        apply(vi(0, 0, 0, 5, 3, 0, 5, 5, 0, 1, 1, 0, 0, 0), ex(4'b0000, 3'b000, 2'b10, 2'b00, 0, 0, 0));
        apply(vi(0, 0, 0, 5, 3, 0, 0, 5, 0, 1, 1, 0, 0, 0), ex(4'b0000, 3'b000, 2'b01, 2'b00, 0, 0, 0));
        apply(vi(0, 0, 0, 5, 3, 0, 0, 0, 0, 1, 1, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
        apply(vi(0, 0, 0, 5, 9, 0, 9, 9, 0, 0, 1, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b01, 0, 0, 0));
        // Load-use on rs2, then counters one cycle later.
        apply(vi(0, 0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 0, 0), ex(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 0));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 1, 1));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 1, 1));
        // Branch beats load-use.
        apply(vi(0, 7, 0, 0, 0, 7, 0, 0, 1, 0, 0, 1, 0, 0), ex(4'b0000, 3'b110, 2'b00, 2'b00, 0, 1, 1));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 1, 2));
        // Three wait cycles with a pending branch, then ready.
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 1, 2));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 2, 2));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 3, 2));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), ex(4'b0000, 3'b110, 2'b00, 2'b00, 0, 4, 2));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 4, 3));
        // Already-ready access: no stall.
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 4, 3));
        // Timeout (MEM_TIMEOUT = 4).
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 4, 3));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 5, 3));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 6, 3));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 0, 7, 3));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), ex(4'b1111, 3'b001, 2'b00, 2'b00, 1, 8, 3));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), ex(4'b1111, 3'b001, 2'b00, 2'b00, 1, 9, 3));
        // Reset out of ERR.
        apply(vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 10, 3));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 0, 0));
        apply(vi(0, 12, 0, 0, 0, 12, 0, 0, 1, 0, 0, 0, 0, 0), ex(4'b1100, 3'b010, 2'b00, 2'b00, 0, 0, 0));
        apply(vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(4'b0000, 3'b000, 2'b00, 2'b00, 0, 1, 1));

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
